// File: rtl/avr_pkg.sv
// Shared definitions for the AVR core fetch path.
//   pc_src_e   : next-PC select encodings driven by the CPU
//   PC_W_DEF   : default program-counter width (words)
//   NOP_OPCODE : instruction word presented when no valid fetch exists
package avr_pkg;

    localparam int          PC_W_DEF   = 16;
    localparam logic [15:0] NOP_OPCODE = 16'h0000;

    typedef enum logic [2:0] {
        PCSRC_INC  = 3'd0,
        PCSRC_REL  = 3'd1,
        PCSRC_ABS  = 3'd2,
        PCSRC_IND  = 3'd3,
        PCSRC_SKIP = 3'd4
    } pc_src_e;

endpackage

// File: rtl/avr_next_pc.sv
// Combinational next-fetch-address mux/adder.
// Ports:
//   fa      in  current fetch address (data for it is on the ROM output)
//   hold    in  re-read fa instead of advancing
//   pc_src  in  next-PC select (avr_pkg::pc_src_e encodings; 5..7 act as INC)
//   jmp     in  signed word offset (REL) or absolute word address (ABS/IND)
//   next_fa out address to present to the ROM
// Build option: AVR_FETCH_WRAP_EN masks the result to PMEM_AW bits so the
// PC wraps at program-memory size; otherwise it wraps modulo 2^PC_W.
module avr_next_pc
    import avr_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int PMEM_AW = 9
) (
    input  logic [PC_W-1:0] fa,
    input  logic            hold,
    input  logic [2:0]      pc_src,
    input  logic [PC_W-1:0] jmp,
    output logic [PC_W-1:0] next_fa
);

`ifdef AVR_FETCH_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [PC_W-1:0] ADDR_MASK =
        WRAP_EN ? PC_W'((64'd1 << PMEM_AW) - 64'd1) : {PC_W{1'b1}};

    logic [PC_W-1:0] raw_fa;

    always_comb begin
        raw_fa = fa + PC_W'(1);
        if (hold) begin
            raw_fa = fa;
        end else begin
            case (pc_src)
                PCSRC_REL:  raw_fa = fa + PC_W'(1) + jmp;
                PCSRC_ABS,
                PCSRC_IND:  raw_fa = jmp;
                PCSRC_SKIP: raw_fa = fa + PC_W'(2);
                default:    raw_fa = fa + PC_W'(1);
            endcase
        end
        next_fa = raw_fa & ADDR_MASK;
    end

endmodule

// File: rtl/avr_fetch_stage.sv
// Instruction-fetch stage between the AVR execute unit and a synchronous
// program ROM with one cycle of read latency.
// Ports:
//   CLK        in  rising-edge clock
//   RST        in  asynchronous active-high reset
//   stall      in  freeze PC and presented instruction
//   pc_src     in  next-PC select from the CPU
//   jmp        in  jump operand (signed offset or absolute word address)
//   prog_data  in  ROM read data for the address issued last cycle
//   prog_addr  out ROM word address (combinational next-fetch address)
//   current_pc out word address of cur_instr
//   cur_instr  out instruction presented to the CPU
// Build option: AVR_FETCH_WRAP_EN (see avr_next_pc) wraps the PC at PMEM_AW bits.
module avr_fetch_stage
    import avr_pkg::*;
#(
    parameter int          PC_W     = PC_W_DEF,
    parameter int          PMEM_AW  = 9,
    parameter logic [15:0] NOP_WORD = NOP_OPCODE
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            stall,
    input  logic [2:0]      pc_src,
    input  logic [PC_W-1:0] jmp,
    input  logic [15:0]     prog_data,
    output logic [PC_W-1:0] prog_addr,
    output logic [PC_W-1:0] current_pc,
    output logic [15:0]     cur_instr
);

    logic [PC_W-1:0] fa;
    logic            vld;
    logic [PC_W-1:0] next_fa;
    logic            hold;

    // Until the first fetch after reset is latched, keep addressing word 0
    // so instruction 0 is the first one presented.
    assign hold = stall | ~vld;

    avr_next_pc #(
        .PC_W    (PC_W),
        .PMEM_AW (PMEM_AW)
    ) u_next_pc (
        .fa      (fa),
        .hold    (hold),
        .pc_src  (pc_src),
        .jmp     (jmp),
        .next_fa (next_fa)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fa  <= '0;
            vld <= 1'b0;
        end else begin
            fa  <= next_fa;
            vld <= 1'b1;
        end
    end

    // During reset the ROM must be parked on word 0 so its data is ready
    // for the first cycle after release.
    assign prog_addr  = RST ? '0 : next_fa;
    assign current_pc = fa;
    assign cur_instr  = vld ? prog_data : NOP_WORD;

endmodule

// File: tb/tb_avr_fetch_stage.sv
module tb_avr_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall;
    logic [2:0]  pc_src;
    logic [15:0] jmp;
    logic [15:0] prog_data;
    logic [15:0] prog_addr;
    logic [15:0] current_pc;
    logic [15:0] cur_instr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    exp_t sb[$];

    logic [15:0] model_fa;
    logic        model_vld;

    always #5 CLK = ~CLK;

    avr_fetch_stage dut (
        .CLK        (CLK),
        .RST        (RST),
        .stall      (stall),
        .pc_src     (pc_src),
        .jmp        (jmp),
        .prog_data  (prog_data),
        .prog_addr  (prog_addr),
        .current_pc (current_pc),
        .cur_instr  (cur_instr)
    );

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    always @(posedge CLK) prog_data <= rom_word(prog_addr);

    function automatic logic [15:0] model_next(input logic [15:0] fa, input logic v,
                                               input logic st, input logic [2:0] src,
                                               input logic [15:0] j);
        logic [15:0] r;
        if (!v || st) r = fa;
        else begin
            case (src)
                3'd1:      r = fa + 16'd1 + j;
                3'd2, 3'd3: r = j;
                3'd4:      r = fa + 16'd2;
                default:   r = fa + 16'd1;
            endcase
        end
`ifdef AVR_FETCH_WRAP_EN
        r = r & 16'h01FF;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a negedge: drive, check the address, clock, check outputs.
    task automatic step(input logic st, input logic [2:0] src, input logic [15:0] j);
        logic [15:0] nxt;
        exp_t e;
        stall  = st;
        pc_src = src;
        jmp    = j;
        #1;
        nxt = model_next(model_fa, model_vld, st, src, j);
        chk("prog_addr", {16'h0, prog_addr}, {16'h0, nxt});
        e.pc    = nxt;
        e.instr = rom_word(nxt);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        model_fa  = nxt;
        model_vld = 1'b1;
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("current_pc", {16'h0, current_pc}, {16'h0, e.pc});
            chk("cur_instr",  {16'h0, cur_instr},  {16'h0, e.instr});
        end
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; stall = 1'b0; pc_src = 3'd0; jmp = 16'h0;
        model_fa = 16'h0; model_vld = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_pc",    {16'h0, current_pc}, 32'h0);
        chk("rst_instr", {16'h0, cur_instr},  32'h0);
        chk("rst_addr_inc", {16'h0, prog_addr}, 32'h0);
        pc_src = 3'd2; jmp = 16'h0055;
        #1;
        chk("rst_addr_abs", {16'h0, prog_addr}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // sequential fetch 0..5
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 16'h0);
        chk("seq_end_pc", {16'h0, model_fa}, 32'h5);
        step(1'b0, 3'd1, 16'hFFFD);          // 5 -> 3
        step(1'b0, 3'd1, 16'hFFFE);          // 3 -> 2
        step(1'b0, 3'd2, 16'h0100);          // ABS
        step(1'b0, 3'd3, 16'h0040);          // IND
        step(1'b0, 3'd2, 16'h0007);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 16'h0005);
        step(1'b0, 3'd1, 16'h0005);          // 7 -> 13 once
        step(1'b0, 3'd2, 16'h000A);
        step(1'b0, 3'd4, 16'h0000);          // 10 -> 12
        step(1'b0, 3'd6, 16'h1234);          // INC
        step(1'b0, 3'd5, 16'h1234);
        step(1'b0, 3'd7, 16'h1234);
        step(1'b0, 3'd1, 16'h0010);          // forward REL
        // wrap cases
        step(1'b0, 3'd2, 16'h01FF);
        step(1'b0, 3'd0, 16'h0000);
        step(1'b0, 3'd2, 16'hFFFF);
        step(1'b0, 3'd0, 16'h0000);
        step(1'b0, 3'd1, 16'h0003);

        // asynchronous reset in the middle of a redirect
        stall = 1'b0; pc_src = 3'd2; jmp = 16'h0123;
        #2;
        RST = 1'b1;
        #1;
        chk("arst_pc",    {16'h0, current_pc}, 32'h0);
        chk("arst_instr", {16'h0, cur_instr},  32'h0);
        chk("arst_addr",  {16'h0, prog_addr},  32'h0);
        model_fa = 16'h0; model_vld = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        step(1'b0, 3'd0, 16'h0);             // instruction 0 first
        step(1'b0, 3'd0, 16'h0);
        step(1'b0, 3'd4, 16'h0);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
